hg_round_judge: RTL and testbench
=================================

Name: hg_round_judge

Overview:
- Parametrised N-player Halli Galli round engine. It generalises the fixed two-player game core to NUM_PLAYERS players, NUM_FRUITS fruit kinds and a configurable bell target.
- Owns per-player deck counters, face-up top cards, centre pile, turn rotation, bell arbitration, penalties, post-bell lockout and game-over detection.
- Sits between the debounced button front-end and the LED/7-seg display drivers inside the top-level game.

Parameters:
- NUM_PLAYERS, 2, number of players (2..8).
- NUM_FRUITS, 4, number of fruit kinds (2..8).
- MAX_COUNT, 5, maximum fruit count printed on one card (1..7).
- TARGET, 5, fruit total that makes a bell valid.
- INIT_CARDS, 28, starting deck size per player.
- CARD_W, 8, deck/pile counter width. Elaboration error if 2^CARD_W <= NUM_PLAYERS*INIT_CARDS.
- PENALTY, 1, cards moved from a false-belling player to the pile.
- LOCK_CYC, 4, input lockout cycles after any bell.
- LFSR_SEED, 16'hACE1, card generator seed. Must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- flip_btn  in  NUM_PLAYERS  per-player flip buttons; synchronised and debounced upstream
- bell_btn  in  NUM_PLAYERS  per-player bell buttons; synchronised and debounced upstream
- dbg_card_en  in  1  when 1, the next flip uses the dbg card below instead of the LFSR
- dbg_fruit  in  3  forced fruit index (verification)
- dbg_count  in  3  forced fruit count (verification)
- top_fruit  out  NUM_PLAYERS*3  face-up fruit per player
- top_count  out  NUM_PLAYERS*3  face-up count per player; 0 = no card
- cards  out  NUM_PLAYERS*CARD_W  remaining deck per player
- pile  out  CARD_W  face-up cards in the centre
- turn  out  3  player whose flip is accepted
- bell_ok  out  1  one-cycle pulse: valid bell taken
- penalty  out  1  one-cycle pulse: false bell
- winner  out  3  player of the most recent bell, valid or false
- state  out  2  IDLE=0, PLAY=1, HOLD=2, OVER=3
- champion  out  3  valid in OVER

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, turn=0, pile=0, winner=0, champion=0
  - every cards=INIT_CARDS
  - every top_count=0 and top_fruit=0
  - bell_ok=0, penalty=0
  - LFSR=LFSR_SEED, button history registers=0
- Press detection: a press is btn=1 while the registered previous sample is 0, evaluated at the rising edge. The action is applied at that edge, so outputs update 1 cycle after the press is sampled.
- IDLE: any flip press moves to PLAY. The card is not flipped on that press.
- PLAY, flip by player p:
  - Accepted only if p==turn and cards[p]>0; all other flip presses are ignored.
  - Card source is dbg_fruit/dbg_count when dbg_card_en=1. Otherwise fruit = lfsr[2:0] mod NUM_FRUITS and count = (lfsr[5:3] mod MAX_COUNT)+1.
  - The new card replaces top[p]; cards[p]-1; pile+1.
  - turn advances to the next index (wrapping) whose cards>0 after the update.
  - The 16-bit Fibonacci LFSR (taps 16,14,13,11) steps once per accepted flip.
- PLAY, bell press:
  - Arbitration: the lowest-index bell press wins; all same-cycle flips are dropped.
  - Each fruit sum is computed over tops at width clog2(NUM_PLAYERS*MAX_COUNT+1).
  - Valid bell (any fruit sum == TARGET): cards[b] += pile; pile=0; all tops cleared; turn=b; winner=b; bell_ok pulses.
  - False bell: m=min(PENALTY,cards[b]); cards[b]-=m; pile+=m; winner=b; penalty pulses.
  - Both outcomes enter HOLD.
- HOLD: all buttons are ignored for LOCK_CYC cycles (down-counter), then state returns to PLAY. Button history keeps updating, so a button held through HOLD does not retrigger.
- Game over: after any update, if at most one player has cards>0, go to OVER.
  - champion = lowest index with maximum cards.
  - OVER ignores all inputs until reset.
- Turn skipping: if turn's cards becomes 0 through a penalty, turn advances as for a flip.
- Counters never overflow, because of the CARD_W elaboration check. No saturation logic is required.

Decomposition:
- Shared include hg_defs.vh holds:
  - state encodings IDLE/PLAY/HOLD/OVER
  - card field widths (3-bit fruit, 3-bit count)
  - LFSR tap constant
- One natural sub-module: hg_card_lfsr (seeded 16-bit LFSR with step enable, outputting fruit/count with the mod mapping).
- Press detection, sums and arbitration stay in hg_round_judge.

Test Plan:
- Reset, defaults → state=0, cards 28/28, pile=0, turn=0, all top_count=0, bell_ok=penalty=0.
- P1 flip in IDLE → state=1, nothing flipped. P1 flip → ignored. P0 flip with dbg fruit0 count2 → cards0=27, pile=1, turn=1.
- Continue: P1 flip fruit0 count3, then P1 bell → bell_ok one cycle, winner=1, cards1=29, pile=0, tops cleared, turn=1, state=2 for 4 cycles, flips ignored during HOLD.
- Tops fruit0=2 and fruit1=2, P0 bell → penalty one cycle, cards0 decreases by 1, pile increases by 1, tops unchanged.
- Tops sum fruit2=5, P0 and P1 bells in the same cycle together with a P0 flip → P0 wins the bell, flip dropped, bell_ok=1, winner=0.
- INIT_CARDS=2: flips P0, P1, P0 → cards0=0, cards1=1 → state=3, champion=1. Further presses leave all outputs unchanged. Asserting rst mid-game restores reset values immediately.

Source files
------------

// File: rtl/hg_round_judge_pkg.sv
// Shared definitions for the Halli Galli round engine: FSM encodings, card field widths
// and the card generator's LFSR feedback taps.
package hg_round_judge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } hg_state_e;

  localparam int FRUIT_W = 3;
  localparam int COUNT_W = 3;
  localparam int LFSR_W  = 16;

  // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/hg_card_lfsr.sv
// Seeded 16-bit Fibonacci LFSR card generator; presents the card for the current
// LFSR value and advances one step whenever a flip is accepted.
module hg_card_lfsr
  import hg_round_judge_pkg::*;
#(
  parameter int NUM_FRUITS = 4,
  parameter int MAX_COUNT  = 5,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  output logic [FRUIT_W-1:0] fruit,
  output logic [COUNT_W-1:0] count
);

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else if (step) begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign fruit = FRUIT_W'({1'b0, lfsr_q[2:0]} % 4'(NUM_FRUITS));
  assign count = COUNT_W'({1'b0, lfsr_q[5:3]} % 4'(MAX_COUNT)) + COUNT_W'(1);

endmodule

// File: rtl/hg_round_judge.sv
// N-player Halli Galli round engine: decks, face-up cards, centre pile, turn order,
// bell arbitration with penalties and lockout, and game-over/champion detection.
//
// state | meaning
// IDLE  | waiting for any flip press to start the game
// PLAY  | flips by the player on turn and bells are accepted
// HOLD  | post-bell lockout, all buttons ignored
// OVER  | at most one player holds cards; frozen until reset
module hg_round_judge
  import hg_round_judge_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_FRUITS  = 4,
  parameter int MAX_COUNT   = 5,
  parameter int TARGET      = 5,
  parameter int INIT_CARDS  = 28,
  parameter int CARD_W      = 8,
  parameter int PENALTY     = 1,
  parameter int LOCK_CYC    = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PLAYERS-1:0]        flip_btn,
  input  logic [NUM_PLAYERS-1:0]        bell_btn,
  input  logic                          dbg_card_en,
  input  logic [2:0]                    dbg_fruit,
  input  logic [2:0]                    dbg_count,
  output logic [NUM_PLAYERS*3-1:0]      top_fruit,
  output logic [NUM_PLAYERS*3-1:0]      top_count,
  output logic [NUM_PLAYERS*CARD_W-1:0] cards,
  output logic [CARD_W-1:0]             pile,
  output logic [2:0]                    turn,
  output logic                          bell_ok,
  output logic                          penalty,
  output logic [2:0]                    winner,
  output logic [1:0]                    state,
  output logic [2:0]                    champion
);

  localparam int SUM_W  = $clog2(NUM_PLAYERS*MAX_COUNT+1);
  localparam int LOCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [CARD_W-1:0] PEN = CARD_W'(PENALTY);

  if ((2**CARD_W) <= NUM_PLAYERS*INIT_CARDS) begin : g_bad_card_w
    $error("CARD_W too narrow for NUM_PLAYERS*INIT_CARDS");
  end
  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  hg_state_e state_q, state_d;
  logic [CARD_W-1:0]  cards_q [NUM_PLAYERS];
  logic [CARD_W-1:0]  cards_d [NUM_PLAYERS];
  logic [FRUIT_W-1:0] fruit_q [NUM_PLAYERS];
  logic [FRUIT_W-1:0] fruit_d [NUM_PLAYERS];
  logic [COUNT_W-1:0] cnt_q   [NUM_PLAYERS];
  logic [COUNT_W-1:0] cnt_d   [NUM_PLAYERS];
  logic [CARD_W-1:0]  pile_q, pile_d, pen_m, best;
  logic [2:0]         turn_q, turn_d, winner_q, winner_d, champ_q, champ_d, bell_idx;
  logic               bell_ok_q, bell_ok_d, penalty_q, penalty_d;
  logic [LOCK_W-1:0]  lock_q, lock_d;
  logic [NUM_PLAYERS-1:0] flip_q, bell_q, flip_press, bell_press;
  logic               step, bell_found, adv_turn, turn_found, bell_valid;
  logic [FRUIT_W-1:0] gen_fruit, card_fruit;
  logic [COUNT_W-1:0] gen_count, card_count;
  logic [SUM_W-1:0]   sums [NUM_FRUITS];
  int                 alive;

  assign flip_press = flip_btn & ~flip_q;
  assign bell_press = bell_btn & ~bell_q;
  assign card_fruit = dbg_card_en ? dbg_fruit : gen_fruit;
  assign card_count = dbg_card_en ? dbg_count : gen_count;

  hg_card_lfsr #(
    .NUM_FRUITS(NUM_FRUITS),
    .MAX_COUNT (MAX_COUNT),
    .SEED      (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .fruit(gen_fruit),
    .count(gen_count)
  );

  // Empty slots carry count 0, so they never contribute to a fruit total
  always_comb begin
    bell_valid = 1'b0;
    for (int f = 0; f < NUM_FRUITS; f++) begin
      sums[f] = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (int'(fruit_q[p]) == f) sums[f] = sums[f] + SUM_W'(cnt_q[p]);
      end
      if (int'(sums[f]) == TARGET) bell_valid = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cards_d    = cards_q;
    fruit_d    = fruit_q;
    cnt_d      = cnt_q;
    pile_d     = pile_q;
    turn_d     = turn_q;
    winner_d   = winner_q;
    champ_d    = champ_q;
    lock_d     = lock_q;
    bell_ok_d  = 1'b0;
    penalty_d  = 1'b0;
    step       = 1'b0;
    adv_turn   = 1'b0;
    turn_found = 1'b0;
    bell_found = 1'b0;
    bell_idx   = '0;
    pen_m      = '0;
    best       = '0;
    alive      = 0;

    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (bell_press[p] && !bell_found) begin
        bell_idx   = 3'(p);
        bell_found = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (|flip_press) state_d = PLAY;
      PLAY: begin
        if (bell_found) begin
          winner_d = bell_idx;
          state_d  = HOLD;
          lock_d   = LOCK_W'(LOCK_CYC-1);
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (p == int'(bell_idx)) begin
              if (bell_valid) begin
                cards_d[p] = cards_q[p] + pile_q;
              end else begin
                pen_m      = (cards_q[p] > PEN) ? PEN : cards_q[p];
                cards_d[p] = cards_q[p] - pen_m;
                pile_d     = pile_q + pen_m;
              end
            end
          end
          if (bell_valid) begin
            pile_d    = '0;
            turn_d    = bell_idx;
            bell_ok_d = 1'b1;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              fruit_d[p] = '0;
              cnt_d[p]   = '0;
            end
          end else begin
            penalty_d = 1'b1;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              if (p == int'(turn_q) && cards_d[p] == '0) adv_turn = 1'b1;
            end
          end
        end else begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (p == int'(turn_q) && flip_press[p] && cards_q[p] != '0) begin
              cards_d[p] = cards_q[p] - CARD_W'(1);
              fruit_d[p] = card_fruit;
              cnt_d[p]   = card_count;
              pile_d     = pile_q + CARD_W'(1);
              step       = 1'b1;
              adv_turn   = 1'b1;
            end
          end
        end

        if (adv_turn) begin
          for (int k = 1; k <= NUM_PLAYERS; k++) begin
            for (int q = 0; q < NUM_PLAYERS; q++) begin
              if (q == (int'(turn_q) + k) % NUM_PLAYERS && !turn_found && cards_d[q] != '0) begin
                turn_d     = 3'(q);
                turn_found = 1'b1;
              end
            end
          end
        end

        // Strict compare keeps the lowest index among tied maxima
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (cards_d[p] != '0) alive = alive + 1;
          if (p == 0 || cards_d[p] > best) begin
            best    = cards_d[p];
            champ_d = 3'(p);
          end
        end
        if (alive > 1) champ_d = champ_q;
        else           state_d = OVER;
      end
      HOLD: begin
        if (lock_q == '0) state_d = PLAY;
        else              lock_d  = lock_q - LOCK_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pile_q    <= '0;
      turn_q    <= '0;
      winner_q  <= '0;
      champ_q   <= '0;
      bell_ok_q <= 1'b0;
      penalty_q <= 1'b0;
      lock_q    <= '0;
      flip_q    <= '0;
      bell_q    <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        cards_q[p] <= CARD_W'(INIT_CARDS);
        fruit_q[p] <= '0;
        cnt_q[p]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      cards_q   <= cards_d;
      fruit_q   <= fruit_d;
      cnt_q     <= cnt_d;
      pile_q    <= pile_d;
      turn_q    <= turn_d;
      winner_q  <= winner_d;
      champ_q   <= champ_d;
      bell_ok_q <= bell_ok_d;
      penalty_q <= penalty_d;
      lock_q    <= lock_d;
      flip_q    <= flip_btn;
      bell_q    <= bell_btn;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
    assign top_fruit[g*3 +: 3]           = fruit_q[g];
    assign top_count[g*3 +: 3]           = cnt_q[g];
    assign cards[g*CARD_W +: CARD_W]     = cards_q[g];
  end

  assign pile     = pile_q;
  assign turn     = turn_q;
  assign bell_ok  = bell_ok_q;
  assign penalty  = penalty_q;
  assign winner   = winner_q;
  assign state    = state_q;
  assign champion = champ_q;

endmodule

// File: tb/tb_hg_round_judge.sv
// Directed bench for hg_round_judge: a default two-player instance for play/bell/lockout
// and a two-card instance for LFSR cards and game-over.
module tb_hg_round_judge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  flip_a = '0, bell_a = '0, flip_b = '0, bell_b = '0;
  logic        dbg_en_a = 1'b0, dbg_en_b = 1'b0;
  logic [2:0]  dbg_fruit_a = '0, dbg_count_a = '0, dbg_fruit_b = '0, dbg_count_b = '0;
  logic [5:0]  top_fruit_a, top_count_a, top_fruit_b, top_count_b;
  logic [15:0] cards_a, cards_b;
  logic [7:0]  pile_a, pile_b;
  logic [2:0]  turn_a, turn_b, winner_a, winner_b, champion_a, champion_b;
  logic        bell_ok_a, bell_ok_b, penalty_a, penalty_b;
  logic [1:0]  state_a, state_b;

  int checks = 0;
  int errors = 0;

  hg_round_judge dut_a (
    .clk(clk), .rst(rst), .flip_btn(flip_a), .bell_btn(bell_a),
    .dbg_card_en(dbg_en_a), .dbg_fruit(dbg_fruit_a), .dbg_count(dbg_count_a),
    .top_fruit(top_fruit_a), .top_count(top_count_a), .cards(cards_a), .pile(pile_a),
    .turn(turn_a), .bell_ok(bell_ok_a), .penalty(penalty_a), .winner(winner_a),
    .state(state_a), .champion(champion_a)
  );

  hg_round_judge #(.INIT_CARDS(2)) dut_b (
    .clk(clk), .rst(rst), .flip_btn(flip_b), .bell_btn(bell_b),
    .dbg_card_en(dbg_en_b), .dbg_fruit(dbg_fruit_b), .dbg_count(dbg_count_b),
    .top_fruit(top_fruit_b), .top_count(top_count_b), .cards(cards_b), .pile(pile_b),
    .turn(turn_b), .bell_ok(bell_ok_b), .penalty(penalty_b), .winner(winner_b),
    .state(state_b), .champion(champion_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One released edge, then one edge with the given buttons pressed; outputs reflect the press on return
  task automatic act_a(input logic [1:0] f, input logic [1:0] b);
    flip_a = '0; bell_a = '0;
    tick();
    flip_a = f; bell_a = b;
    tick();
    flip_a = '0; bell_a = '0;
  endtask

  task automatic act_b(input logic [1:0] f, input logic [1:0] b);
    flip_b = '0; bell_b = '0;
    tick();
    flip_b = f; bell_b = b;
    tick();
    flip_b = '0; bell_b = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check("rst_state",  state_a, 0);
    check("rst_cards",  cards_a, {8'd28, 8'd28});
    check("rst_pile",   pile_a, 0);
    check("rst_turn",   turn_a, 0);
    check("rst_tops",   top_count_a, 0);
    check("rst_pulses", {bell_ok_a, penalty_a}, 0);
    check("rst_cards_b", cards_b, {8'd2, 8'd2});
    rst = 1'b1;
    tick();

    act_a(2'b10, 2'b00);
    check("idle_start_state", state_a, 1);
    check("idle_start_noflip", {cards_a, pile_a}, {8'd28, 8'd28, 8'd0});

    act_a(2'b10, 2'b00);
    check("wrong_turn_ignored", {cards_a, pile_a, 5'd0, turn_a}, {8'd28, 8'd28, 8'd0, 8'd0});

    dbg_en_a = 1'b1; dbg_fruit_a = 3'd0; dbg_count_a = 3'd2;
    act_a(2'b01, 2'b00);
    check("p0_flip_cards", cards_a, {8'd28, 8'd27});
    check("p0_flip_pile",  pile_a, 1);
    check("p0_flip_turn",  turn_a, 1);
    check("p0_flip_top",   {top_fruit_a[2:0], top_count_a[2:0]}, {3'd0, 3'd2});

    dbg_count_a = 3'd3;
    act_a(2'b10, 2'b00);
    check("p1_flip", {cards_a, pile_a, 5'd0, turn_a}, {8'd27, 8'd27, 8'd2, 8'd0});
    check("p1_flip_top", {top_fruit_a[5:3], top_count_a[5:3]}, {3'd0, 3'd3});

    act_a(2'b00, 2'b10);
    check("bell_ok_pulse", {bell_ok_a, penalty_a}, 2'b10);
    check("bell_winner",   winner_a, 1);
    check("bell_cards",    cards_a, {8'd29, 8'd27});
    check("bell_pile",     pile_a, 0);
    check("bell_tops",     top_count_a, 0);
    check("bell_turn",     turn_a, 1);
    check("bell_hold",     state_a, 2);
    flip_a = 2'b10;
    tick();
    check("hold_c1", {state_a, bell_ok_a}, {2'd2, 1'b0});
    check("hold_flip_ignored", {cards_a, pile_a}, {8'd29, 8'd27, 8'd0});
    flip_a = 2'b00;
    tick();
    check("hold_c2", state_a, 2);
    tick();
    check("hold_c3", state_a, 2);
    tick();
    check("hold_end", state_a, 1);

    dbg_fruit_a = 3'd1; dbg_count_a = 3'd2;
    act_a(2'b10, 2'b00);
    check("setup_p1", {cards_a, pile_a, 5'd0, turn_a}, {8'd28, 8'd27, 8'd1, 8'd0});
    dbg_fruit_a = 3'd0; dbg_count_a = 3'd2;
    act_a(2'b01, 2'b00);
    check("setup_p0", {cards_a, pile_a, 5'd0, turn_a}, {8'd28, 8'd26, 8'd2, 8'd1});
    act_a(2'b00, 2'b01);
    check("false_bell_pulse", {bell_ok_a, penalty_a}, 2'b01);
    check("false_bell_cards", cards_a, {8'd28, 8'd25});
    check("false_bell_pile",  pile_a, 3);
    check("false_bell_tops",  {top_fruit_a, top_count_a}, {3'd1, 3'd0, 3'd2, 3'd2});
    check("false_bell_winner_state", {winner_a, state_a}, {3'd0, 2'd2});
    tick();
    check("penalty_one_cycle", penalty_a, 0);
    tick(); tick(); tick();
    check("false_hold_end", state_a, 1);

    dbg_fruit_a = 3'd2; dbg_count_a = 3'd5;
    act_a(2'b10, 2'b00);
    check("fruit2_flip", {cards_a, pile_a, 5'd0, turn_a}, {8'd27, 8'd25, 8'd4, 8'd0});
    act_a(2'b01, 2'b11);
    check("arb_bell_ok", {bell_ok_a, penalty_a}, 2'b10);
    check("arb_winner",  winner_a, 0);
    check("arb_cards",   cards_a, {8'd27, 8'd29});
    check("arb_pile_turn", {pile_a, 5'd0, turn_a}, {8'd0, 8'd0});

    act_b(2'b01, 2'b00);
    check("b_start", {state_b, cards_b}, {2'd1, 8'd2, 8'd2});
    act_b(2'b01, 2'b00);
    check("b_flip0", {cards_b, pile_b, 5'd0, turn_b}, {8'd2, 8'd1, 8'd1, 8'd1});
    check("b_lfsr_card0", {top_fruit_b[2:0], top_count_b[2:0]}, {3'd1, 3'd5});
    act_b(2'b10, 2'b00);
    check("b_flip1", {cards_b, pile_b, 5'd0, turn_b}, {8'd1, 8'd1, 8'd2, 8'd0});
    check("b_lfsr_card1", {top_fruit_b[5:3], top_count_b[5:3]}, {3'd3, 3'd1});
    act_b(2'b01, 2'b00);
    check("b_over_state", state_b, 3);
    check("b_over_champion", champion_b, 1);
    check("b_over_cards", {cards_b, pile_b}, {8'd1, 8'd0, 8'd3});
    check("b_lfsr_card2", {top_fruit_b[2:0], top_count_b[2:0]}, {3'd3, 3'd1});
    act_b(2'b10, 2'b00);
    check("b_over_flip_ignored", {cards_b, pile_b, 6'd0, state_b}, {8'd1, 8'd0, 8'd3, 8'd3});
    act_b(2'b00, 2'b10);
    check("b_over_bell_ignored", {bell_ok_b, penalty_b, winner_b, pile_b}, {1'b0, 1'b0, 3'd0, 8'd3});
    check("b_over_tops_kept", top_count_b, {3'd1, 3'd1});

    #3;
    rst = 1'b0;
    #1;
    check("async_rst_a", {state_a, pile_a, cards_a}, {2'd0, 8'd0, 8'd28, 8'd28});
    check("async_rst_a_out", {turn_a, winner_a, top_count_a}, 12'd0);
    check("async_rst_b", {state_b, champion_b, cards_b}, {2'd0, 3'd0, 8'd2, 8'd2});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
